// File: rtl/wave_pkg.sv
// Shared geometry defaults, coordinate types and the triangle height rule
// used by the bar-wave renderer and its height lookup.
package wave_pkg;

  typedef logic [9:0]  coord_t;
  typedef logic [10:0] cmp_t;
  typedef logic [3:0]  bar_idx_t;
  typedef logic [7:0]  height_t;

  localparam int DEF_BAR_W      = 40;
  localparam int DEF_VIS_W      = 25;
  localparam int DEF_N_BARS     = 10;
  localparam int DEF_H_STEP     = 10;
  localparam int DEF_BASE_H     = 60;
  localparam int DEF_X_LO       = 100;
  localparam int DEF_X_HI       = 540;
  localparam int DEF_TOP_Y      = 180;
  localparam int DEF_BOT_Y      = 400;
  localparam int DEF_PLAYER_X   = 200;
  localparam int DEF_Y_CENTER   = 290;
  localparam int DEF_TRACK_STEP = 8;

  // Tallest bar cut-out; the top band limit is offset by this so bar N/2 is tallest.
  function automatic int calc_hmax(input int h_step, input int n_bars);
    return h_step * n_bars / 2;
  endfunction

  function automatic int tri_height(input int idx, input int h_step, input int n_bars);
    int half;
    half = n_bars / 2;
    return h_step * ((idx > half) ? (idx - half) : (half - idx));
  endfunction

endpackage

// File: rtl/bar_height_lut.sv
// Triangle height table: maps a bar index within the wave period to its
// height cut h(i) = H_STEP*|i - N_BARS/2|.
module bar_height_lut
  import wave_pkg::*;
#(
  parameter int H_STEP = DEF_H_STEP,
  parameter int N_BARS = DEF_N_BARS
) (
  input  logic [3:0] idx,
  output logic [7:0] h
);

  always_comb begin
    h = '0;
    for (int i = 0; i < 16; i++) begin
      if (idx == bar_idx_t'(i)) begin
        h = height_t'(tri_height(i, H_STEP, N_BARS));
      end
    end
  end

endmodule

// File: rtl/wave_bar_renderer.sv
// Mirrored bar-wave pixel renderer with frame-stepped scrolling and a
// rate-limited sprite anchor that follows the bar under PLAYER_X.
module wave_bar_renderer
  import wave_pkg::*;
#(
  parameter int BAR_W      = DEF_BAR_W,
  parameter int VIS_W      = DEF_VIS_W,
  parameter int N_BARS     = DEF_N_BARS,
  parameter int H_STEP     = DEF_H_STEP,
  parameter int BASE_H     = DEF_BASE_H,
  parameter int X_LO       = DEF_X_LO,
  parameter int X_HI       = DEF_X_HI,
  parameter int TOP_Y      = DEF_TOP_Y,
  parameter int BOT_Y      = DEF_BOT_Y,
  parameter int PLAYER_X   = DEF_PLAYER_X,
  parameter int Y_CENTER   = DEF_Y_CENTER,
  parameter int TRACK_STEP = DEF_TRACK_STEP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       display_on,
  input  logic       vsync,
  input  logic [2:0] speed,
  input  logic       dir,
  input  logic       pause,
  output logic       draw_wave,
  output logic       frame_tick,
  output logic [9:0] player_y,
  output logic       player_valid
);

  localparam int HMAX = calc_hmax(H_STEP, N_BARS);

  localparam coord_t   BAR_W_X   = coord_t'(BAR_W);
  localparam coord_t   VIS_W_X   = coord_t'(VIS_W);
  localparam bar_idx_t BAR_LAST  = bar_idx_t'(N_BARS - 1);
  localparam cmp_t     BAR_W_C   = cmp_t'(BAR_W);
  localparam cmp_t     X_LO_C    = cmp_t'(X_LO);
  localparam cmp_t     X_HI_C    = cmp_t'(X_HI);
  localparam cmp_t     TOP_Y_C   = cmp_t'(TOP_Y);
  localparam cmp_t     BOT_Y_C   = cmp_t'(BOT_Y);
  localparam cmp_t     BASE_H_C  = cmp_t'(BASE_H);
  localparam cmp_t     TOP_LIM_C = cmp_t'(TOP_Y + BASE_H + HMAX);
  localparam coord_t   PLAYER_XC = coord_t'(PLAYER_X);
  localparam coord_t   Y_CENTERC = coord_t'(Y_CENTER);
  localparam coord_t   TGT_BASE  = coord_t'(Y_CENTER + 25);
  localparam coord_t   STEP_X    = coord_t'(TRACK_STEP);

  if (BAR_W <= 7 || VIS_W > BAR_W || (N_BARS % 2) != 0 || N_BARS > 16) begin : g_bad_geometry
    $error("wave_bar_renderer: invalid bar geometry parameters");
  end

  function automatic bar_idx_t bar_inc(input bar_idx_t b);
    return (b == BAR_LAST) ? '0 : b + bar_idx_t'(1);
  endfunction

  function automatic bar_idx_t bar_dec(input bar_idx_t b);
    return (b == '0) ? BAR_LAST : b - bar_idx_t'(1);
  endfunction

  // Saturating move toward the target: never more than TRACK_STEP per frame.
  function automatic coord_t step_toward(input coord_t cur, input coord_t target);
    coord_t diff;
    if (target > cur) begin
      diff = target - cur;
      return cur + ((diff > STEP_X) ? STEP_X : diff);
    end
    diff = cur - target;
    return cur - ((diff > STEP_X) ? STEP_X : diff);
  endfunction

  logic     vs_q;
  bar_idx_t off_bar;
  coord_t   off_pos;
  cmp_t     fwd_sum;
  bar_idx_t col_bar_q, cur_bar, nxt_bar;
  coord_t   col_pos_q, cur_pos, nxt_pos;
  height_t  h_col, h_trk;
  coord_t   tgt;
  cmp_t     x_c, y_c, top_lim, bot_lim;
  logic     lit_p0, top_p0, bot_p0, win_p0, draw_p0;
  logic     draw_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= vsync;
    end
  end

  assign frame_tick = vsync & ~vs_q;

  assign fwd_sum = cmp_t'(off_pos) + cmp_t'(speed);

  // Scroll offset kept as (bar, position) so no divider is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      off_bar <= '0;
      off_pos <= '0;
    end else if (frame_tick && !pause && speed != 3'd0) begin
      if (!dir) begin
        if (fwd_sum >= BAR_W_C) begin
          off_pos <= coord_t'(fwd_sum - BAR_W_C);
          off_bar <= bar_inc(off_bar);
        end else begin
          off_pos <= coord_t'(fwd_sum);
        end
      end else if (off_pos < coord_t'(speed)) begin
        off_pos <= off_pos + BAR_W_X - coord_t'(speed);
        off_bar <= bar_dec(off_bar);
      end else begin
        off_pos <= off_pos - coord_t'(speed);
      end
    end
  end

  // Registers hold the counters predicted for pix_x+1; at pix_x==0 the offset is used directly.
  always_comb begin
    cur_pos = col_pos_q;
    cur_bar = col_bar_q;
    if (pix_x == '0) begin
      cur_pos = off_pos;
      cur_bar = off_bar;
    end
    nxt_pos = cur_pos + coord_t'(1);
    nxt_bar = cur_bar;
    if (nxt_pos == BAR_W_X) begin
      nxt_pos = '0;
      nxt_bar = bar_inc(cur_bar);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_pos_q <= '0;
      col_bar_q <= '0;
    end else begin
      col_pos_q <= nxt_pos;
      col_bar_q <= nxt_bar;
    end
  end

  bar_height_lut #(.H_STEP(H_STEP), .N_BARS(N_BARS)) u_col_lut (
    .idx (cur_bar),
    .h   (h_col)
  );

  bar_height_lut #(.H_STEP(H_STEP), .N_BARS(N_BARS)) u_trk_lut (
    .idx (cur_bar),
    .h   (h_trk)
  );

  // Stage p0: combinational pixel decision on the current raster position.
  always_comb begin
    x_c     = {1'b0, pix_x};
    y_c     = {1'b0, pix_y};
    top_lim = TOP_LIM_C - cmp_t'(h_col);
    bot_lim = BOT_Y_C - cmp_t'(h_col) - BASE_H_C;
    lit_p0  = cur_pos < VIS_W_X;
    top_p0  = lit_p0 && (y_c > TOP_Y_C) && (y_c < top_lim);
    bot_p0  = lit_p0 && (y_c > bot_lim) && (y_c < BOT_Y_C);
    win_p0  = (x_c > X_LO_C) && (x_c < X_HI_C) && (y_c > TOP_Y_C) && (y_c < BOT_Y_C);
    draw_p0 = display_on && (top_p0 || bot_p0) && win_p0;
  end

  // Stage p1: registered pixel flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      draw_p1 <= 1'b0;
    end else begin
      draw_p1 <= draw_p0;
    end
  end

  assign draw_wave = draw_p1;

  // A target latched in the tick cycle only takes effect on the following frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt          <= '0;
      player_y     <= Y_CENTERC;
      player_valid <= 1'b0;
    end else begin
      if (pix_y == '0 && pix_x == PLAYER_XC) begin
        tgt <= TGT_BASE - coord_t'(h_trk);
      end
      if (frame_tick) begin
        player_y     <= step_toward(player_y, tgt);
        player_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wave_bar_renderer.sv
// Randomized scoreboard bench for wave_bar_renderer against a pixel-offset
// reference model of the scrolling wave, frame strobe and sprite tracker.
module tb_wave_bar_renderer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       display_on, vsync;
  logic [2:0] speed;
  logic       dir, pause;
  logic       draw_wave, frame_tick;
  logic [9:0] player_y;
  logic       player_valid;

  always #5 clk = ~clk;

  wave_bar_renderer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .display_on   (display_on),
    .vsync        (vsync),
    .speed        (speed),
    .dir          (dir),
    .pause        (pause),
    .draw_wave    (draw_wave),
    .frame_tick   (frame_tick),
    .player_y     (player_y),
    .player_valid (player_valid)
  );

  localparam int K_DRAW = 0;
  localparam int K_TICK = 1;
  localparam int K_PY   = 2;
  localparam int K_PV   = 3;

  typedef struct {
    int kind;
    int due;
    int exp;
  } chk_t;

  chk_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  // Next-cycle control inputs, applied by step() right after the clock edge.
  bit n_rstn  = 1'b0;
  bit n_vs    = 1'b0;
  int n_spd   = 0;
  bit n_dir   = 1'b0;
  bit n_pause = 1'b0;

  // Reference model: scroll offset as a single pixel count modulo one wave period.
  int m_off = 0, m_line_off = 0, m_prev_x = 0;
  bit m_line_ok = 1'b0, m_known = 1'b0, m_vsq = 1'b1, m_pv = 1'b0;
  int m_tgt = 0, m_py = 290;

  always @(posedge clk) cyc++;

  function automatic int h_of(input int i);
    return 10 * ((i > 5) ? (i - 5) : (5 - i));
  endfunction

  function automatic bit in_win(input int x, input int y);
    return (x > 100) && (x < 540) && (y > 180) && (y < 400);
  endfunction

  function automatic bit exp_draw(input int x, input int y, input bit de, input int off);
    int bar, pos, h;
    bar = ((x + off) / 40) % 10;
    pos = (x + off) % 40;
    h   = h_of(bar);
    if (!de || !in_win(x, y) || pos >= 25) return 1'b0;
    return (y < 180 + 60 + 50 - h) || (y > 400 - h - 60);
  endfunction

  function automatic int move_to(input int cur, input int target);
    int d;
    d = target - cur;
    if (d > 8) d = 8;
    if (d < -8) d = -8;
    return cur + d;
  endfunction

  function automatic void push(input int k, input int d, input int v);
    chk_t e;
    e.kind = k;
    e.due  = d;
    e.exp  = v;
    q.push_back(e);
  endfunction

  task automatic step(input int x, input int y, input bit de);
    int c, ntgt;
    bit tick;
    @(posedge clk);
    #1;
    pix_x      = 10'(x);
    pix_y      = 10'(y);
    display_on = de;
    vsync      = n_vs;
    speed      = 3'(n_spd);
    dir        = n_dir;
    pause      = n_pause;
    rst_n      = n_rstn;
    c = cyc;
    if (!(x == 0 || x == m_prev_x + 1)) m_line_ok = 1'b0;
    m_prev_x = x;
    if (!n_rstn) begin
      push(K_DRAW, c + 1, 0);
      m_off = 0; m_tgt = 0; m_py = 290; m_pv = 1'b0;
      m_vsq = 1'b1; m_known = 1'b1; m_line_ok = 1'b0;
    end else if (m_known) begin
      tick = n_vs && !m_vsq;
      push(K_TICK, c, int'(tick));
      if (x == 0) begin
        m_line_off = m_off;
        m_line_ok  = 1'b1;
      end
      if (m_line_ok) push(K_DRAW, c + 1, int'(exp_draw(x, y, de, m_line_off)));
      else if (!in_win(x, y)) push(K_DRAW, c + 1, 0);
      ntgt = m_tgt;
      if (y == 0 && x == 200) ntgt = 315 - h_of(((200 + m_line_off) / 40) % 10);
      if (tick) begin
        m_py = move_to(m_py, m_tgt);
        m_pv = 1'b1;
        if (!n_pause) m_off = n_dir ? (m_off - n_spd + 400) % 400 : (m_off + n_spd) % 400;
      end
      m_tgt = ntgt;
      m_vsq = n_vs;
    end
    if (m_known) begin
      push(K_PY, c + 1, m_py);
      push(K_PV, c + 1, int'(m_pv));
    end
  endtask

  task automatic do_reset();
    n_rstn = 1'b0;
    repeat (3) step(799, 500, 1'b0);
    n_rstn = 1'b1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      n_vs = 1'b1;
      step(799, 500, 1'b0);
      n_vs = 1'b0;
      step(799, 500, 1'b0);
    end
  endtask

  task automatic line(input int y, input bit de, input int tick_x, input int rst_x);
    for (int x = 0; x <= 560; x++) begin
      n_vs   = (x == tick_x);
      n_rstn = (x != rst_x);
      step(x, y, de);
    end
    n_vs   = 1'b0;
    n_rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    chk_t        e;
    logic [31:0] act;
    string       nm;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      case (e.kind)
        K_DRAW:  begin act = {31'b0, draw_wave};    nm = "draw_wave";    end
        K_TICK:  begin act = {31'b0, frame_tick};   nm = "frame_tick";   end
        K_PY:    begin act = {22'b0, player_y};     nm = "player_y";     end
        default: begin act = {31'b0, player_valid}; nm = "player_valid"; end
      endcase
      total++;
      if (act !== 32'(e.exp)) begin
        bad++;
        $display("FAIL %s cyc=%0d x=%0d y=%0d got=%0d want=%0d", nm, cyc, pix_x, pix_y, act, e.exp);
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with vsync held high: no tick until vsync falls and rises again.
    n_vs = 1'b1;
    do_reset();
    n_vs = 1'b1;
    repeat (3) step(799, 500, 1'b0);
    n_vs = 1'b0;
    step(799, 500, 1'b0);

    // Offset 0 pixels, then forward scroll at speed 4.
    line(200, 1'b1, -1, -1);
    line(275, 1'b1, -1, -1);
    line(390, 1'b1, -1, -1);
    line(390, 1'b0, -1, -1);
    n_spd = 4; n_dir = 1'b0;
    ticks(10);
    line(200, 1'b1, -1, -1);
    ticks(90);
    line(200, 1'b1, -1, -1);

    // Reverse one tick, then paused ticks.
    do_reset();
    n_spd = 4; n_dir = 1'b1;
    ticks(1);
    line(390, 1'b1, -1, -1);
    n_pause = 1'b1;
    ticks(5);
    line(200, 1'b1, -1, -1);
    n_pause = 1'b0;

    // Tracker from reset toward bar 5, then a mid-line reset.
    do_reset();
    line(0, 1'b1, -1, -1);
    ticks(6);
    n_spd = 7; n_dir = 1'b0;
    ticks(3);
    line(200, 1'b1, -1, 121);
    line(200, 1'b1, -1, -1);

    for (int it = 0; it < 30; it++) begin
      n_spd   = $urandom_range(0, 7);
      n_dir   = 1'($urandom_range(0, 1));
      n_pause = ($urandom_range(0, 3) == 0);
      ticks($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) line(0, 1'b1, ($urandom_range(0, 1) != 0) ? 200 : -1, -1);
      else line($urandom_range(170, 410), ($urandom_range(0, 7) != 0), -1, -1);
      if (it % 10 == 9) do_reset();
    end

    repeat (3) step(799, 500, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_bar_renderer.md
# wave_bar_renderer

Parametrised, frame-animated renderer for the mirrored bar-wave scene and its tracking sprite anchor. It consumes the raster position and sync from the VGA timing generator and produces one registered per-pixel `draw_wave` flag, plus a smoothed `player_y` for the sprite stage. It replaces combinational divide/modulo wave drawing with incremental per-line counters. It adds speed, direction and pause control, and rate-limited sprite tracking.

## Interface
- `BAR_W`, 40: bar pitch in pixels; must be greater than 7.
- `VIS_W`, 25: lit width of each bar; must be at most `BAR_W`.
- `N_BARS`, 10: bars per wave period; must be even and at most 16.
- `H_STEP`, 10: height step per bar index.
- `BASE_H`, 60: minimum bar height.
- `X_LO`, 100 and `X_HI`, 540: exclusive horizontal window.
- `TOP_Y`, 180 and `BOT_Y`, 400: exclusive vertical window.
- `PLAYER_X`, 200: column sampled for the sprite target.
- `Y_CENTER`, 290: sprite baseline and reset value.
- `TRACK_STEP`, 8: maximum sprite move per frame.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset. Synchronous, active-low.
- `pix_x`, `pix_y` in 10: raster position from the timing generator.
- `display_on` in 1: active video.
- `vsync` in 1: vertical sync, active-high, same clock domain.
- `speed` in 3: pixels of scroll per frame.
- `dir` in 1: 0 scrolls left (offset increases); 1 reverses.
- `pause` in 1: freezes the scroll offset.
- `draw_wave` out 1: registered wave pixel, already gated by `display_on`.
- `frame_tick` out 1: one-cycle pulse on the rising edge of `vsync`.
- `player_y` out 10: smoothed sprite y.
- `player_valid` out 1: high from the first `frame_tick` after reset.

## Operation
Definitions:
- `HMAX = H_STEP*N_BARS/2`.
- `h(i) = H_STEP*|i - N_BARS/2|`. This is the triangle LUT; for defaults it gives 50,40,…,0,…,40.

Frame strobe:
- `vs_q` registers `vsync`.
- `frame_tick = vsync & ~vs_q`.
- `vs_q` resets to 1, so there is no spurious tick if `vsync` is high when reset is released.

Scroll offset:
- Held as `off_bar` (0..N_BARS-1) and `off_pos` (0..BAR_W-1). No divider is used.
- On `frame_tick` with `pause=0`, forward (`dir=0`):
  - `off_pos += speed`.
  - If the result is at least `BAR_W`, subtract `BAR_W` and advance `off_bar` mod `N_BARS`.
- Reverse (`dir=1`):
  - If `off_pos < speed`, set `off_pos = off_pos + BAR_W - speed` and decrement `off_bar` (0 wraps to N_BARS-1).
  - Otherwise `off_pos -= speed`.
- `speed=0` or `pause=1` holds the offset.
- `speed` and `dir` are sampled only on `frame_tick`.

Column counters (`col_pos`, `col_bar`):
- When `pix_x==0`, load them from `off_pos` and `off_bar`.
- Otherwise increment `col_pos`. When it wraps at `BAR_W`, set it to 0 and advance `col_bar` mod `N_BARS`.
- Result: `col_bar` = ((pix_x+offset)/BAR_W) mod N_BARS and `col_pos` = (pix_x+offset) mod BAR_W for the current pixel.

Pixel decision (combinational, then registered):
- `top` = `col_pos < VIS_W` and `TOP_Y < pix_y < TOP_Y + BASE_H + HMAX - h(col_bar)`.
- `bot` = `col_pos < VIS_W` and `BOT_Y - h - BASE_H < pix_y < BOT_Y`.
- `draw_wave <= display_on & (top|bot) & X_LO<pix_x<X_HI & TOP_Y<pix_y<BOT_Y`.

Sprite tracker:
- When `pix_y==0` and `pix_x==PLAYER_X`, latch `tgt = Y_CENTER + 25 - h(col_bar)`.
- On `frame_tick`, move `player_y` toward `tgt` by `min(|tgt-player_y|, TRACK_STEP)`.
- Set `player_valid` on the same `frame_tick`.

Arithmetic and widths:
- All comparisons are 11-bit unsigned, so windows cannot wrap.
- `h` is 8-bit.

## Timing
- `draw_wave` has a latency of 1 cycle from `pix_x`/`pix_y`. The consumer delays sync by one cycle to match.
- Offset and `player_y` change only in the cycle after `frame_tick`, so they are stable for a whole frame.
- On reset, all outputs and state are 0, except `vs_q`=1 and `player_y`=`Y_CENTER`. `player_valid`=0.
- Reset mid-frame: reset values take effect on the next edge. Column counters reload at the next `pix_x==0`.
- When `frame_tick` and the target latch coincide, the step uses the previous `tgt`.

## Structure
- Shared package `wave_pkg`: `HMAX` derivation, default geometry constants, 10-bit coordinate typedef.
- One sub-module `bar_height_lut` (index to `h`), instanced twice: once for the column and once for the tracker.

## Test plan
- Reset, `speed=4`, `dir=0`, 10 ticks: `off_bar=1`, `off_pos=0`. After 100 ticks: `off_bar=0`, `off_pos=0`.
- Reset, `speed=4`, `dir=1`, 1 tick: `off_bar=9`, `off_pos=36`. With `pause=1`, 5 further ticks leave it unchanged.
- Offset 0: pixel (120,200) gives `draw_wave=1`, because bar 3, h=20, top limit 270. Pixel (120,275) gives 0. Pixel (145,200) gives 0, because `col_pos=25`. Pixel (100,200) gives 0, because it is outside the window.
- Offset 0: pixel (300,390) gives 1, because bar 7, h=20, so the band is 320 to 400. `display_on=0` forces 0.
- Tracker from reset with `tgt=315` (bar 5): `player_y` goes 298, 306, 314, 315, then holds. `player_valid` rises on the first tick.
- Assert reset with `vsync` high, then release: no `frame_tick` until `vsync` falls and rises again. Reset asserted mid-line clears `draw_wave` the next cycle.
